mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port DEPTH-word memory.
- Accepts one read or write per cycle from requester 0 or 1 and registers the winning command onto the mem_* bus.
- Returns read data to the originating requester with fixed latency.
- Round-robin fairness, with an optional bounded burst lock per requester.

---
 rtl/mem_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter and sequencer in front of a
// single-port memory. The winning command is registered onto the mem_* bus,
// and read data is routed back to the originator two cycles after its grant.
// An owner may hold the grant with its lock input for at most MAX_BURST
// consecutive beats while the other requester is waiting.
// Optional feature: define MEM_ARB_PERF_EN to add the m0_beats, m1_beats and
// stall_cnt performance counters.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int MAX_BURST  = 8,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]           m0_beats,
    output logic [31:0]           m1_beats,
    output logic [31:0]           stall_cnt,
`endif
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    // Arbitration state
    logic                  last_grant_q, last_grant_d;
    logic                  lock_valid_q, lock_valid_d;
    logic                  lock_owner_q, lock_owner_d;
    logic [CNT_W-1:0]      burst_cnt_q,  burst_cnt_d;

    // Registered memory command
    logic                  mem_en_q,    mem_en_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    // Read return pipeline: stage 1 tracks the read on the mem bus,
    // stage 2 is the per-requester rvalid.
    logic                  rd1_valid_q, rd1_valid_d;
    logic                  rd1_tag_q,   rd1_tag_d;
    logic                  m0_rvalid_q, m0_rvalid_d;
    logic                  m1_rvalid_q, m1_rvalid_d;

`ifdef MEM_ARB_PERF_EN
    logic [31:0]           m0_beats_q,  m0_beats_d;
    logic [31:0]           m1_beats_q,  m1_beats_d;
    logic [31:0]           stall_cnt_q, stall_cnt_d;
`endif

    logic                  owner_req;
    logic                  other_req;
    logic                  accept;
    logic                  sel;
    logic                  sel_we;
    logic                  sel_lock;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    assign owner_req = lock_owner_q ? m1_req : m0_req;
    assign other_req = lock_owner_q ? m0_req : m1_req;

    // Grant decision: lock override first, then round-robin on ties; no grant in reset
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (ARESETn) begin
            if (lock_valid_q && owner_req) begin
                if ((burst_cnt_q >= BURST_MAX) && other_req) begin
                    m0_gnt = lock_owner_q;
                    m1_gnt = ~lock_owner_q;
                end else begin
                    m0_gnt = ~lock_owner_q;
                    m1_gnt = lock_owner_q;
                end
            end else if (m0_req && m1_req) begin
                m0_gnt = last_grant_q;
                m1_gnt = ~last_grant_q;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    assign accept    = m0_gnt | m1_gnt;
    assign sel       = m1_gnt;
    assign sel_we    = sel ? m1_we    : m0_we;
    assign sel_lock  = sel ? m1_lock  : m0_lock;
    assign sel_addr  = sel ? m1_addr  : m0_addr;
    assign sel_wdata = sel ? m1_wdata : m0_wdata;

    // Next-state logic for the command register, lock tracking and read pipeline
    always_comb begin
        last_grant_d = last_grant_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        burst_cnt_d  = burst_cnt_q;
        mem_en_d     = accept;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rd1_valid_d  = accept & ~sel_we;
        rd1_tag_d    = sel;
        m0_rvalid_d  = rd1_valid_q & ~rd1_tag_q;
        m1_rvalid_d  = rd1_valid_q & rd1_tag_q;
        if (accept) begin
            last_grant_d = sel;
            mem_we_d     = sel_we;
            mem_addr_d   = sel_addr;
            mem_wdata_d  = sel_wdata;
            if (sel_lock) begin
                lock_valid_d = 1'b1;
                lock_owner_d = sel;
                if (lock_valid_q && (lock_owner_q == sel)) begin
                    burst_cnt_d = (burst_cnt_q >= BURST_MAX) ? BURST_MAX
                                                             : burst_cnt_q + CNT_W'(1);
                end else begin
                    burst_cnt_d = CNT_W'(1);
                end
            end else begin
                lock_valid_d = 1'b0;
                lock_owner_d = 1'b0;
                burst_cnt_d  = '0;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    // Performance counters: accepted beats per requester and cycles with a waiting requester
    always_comb begin
        m0_beats_d  = m0_beats_q;
        m1_beats_d  = m1_beats_q;
        stall_cnt_d = stall_cnt_q;
        if (m0_gnt) begin
            m0_beats_d = m0_beats_q + 32'd1;
        end
        if (m1_gnt) begin
            m1_beats_d = m1_beats_q + 32'd1;
        end
        if ((m0_req && !m0_gnt) || (m1_req && !m1_gnt)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter registers, cleared on reset and wrapping naturally
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            m0_beats_q  <= '0;
            m1_beats_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            m0_beats_q  <= m0_beats_d;
            m1_beats_q  <= m1_beats_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign m0_beats  = m0_beats_q;
    assign m1_beats  = m1_beats_q;
    assign stall_cnt = stall_cnt_q;
`endif

    // State registers; reset drops in-flight reads and favours requester 0 on the first tie
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            last_grant_q <= 1'b1;
            lock_valid_q <= 1'b0;
            lock_owner_q <= 1'b0;
            burst_cnt_q  <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd1_valid_q  <= 1'b0;
            rd1_tag_q    <= 1'b0;
            m0_rvalid_q  <= 1'b0;
            m1_rvalid_q  <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rd1_valid_q  <= rd1_valid_d;
            rd1_tag_q    <= rd1_tag_d;
            m0_rvalid_q  <= m0_rvalid_d;
            m1_rvalid_q  <= m1_rvalid_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    // The memory output register already holds the data; only the originator sees it
    assign m0_rdata  = m0_rvalid_q ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid_q ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a small
// single-port memory model whose read data appears the cycle after sampling.
module tb_mem_arbiter;

    logic        ACLK;
    logic        ARESETn;
    logic        m0_req, m0_we, m0_lock;
    logic [9:0]  m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_lock;
    logic [9:0]  m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] m0_beats, m1_beats, stall_cnt;
`endif

    logic [31:0] mem_model [0:1023];

    int checks   = 0;
    int failures = 0;

    mem_arbiter dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
`ifdef MEM_ARB_PERF_EN
        .m0_beats  (m0_beats),
        .m1_beats  (m1_beats),
        .stall_cnt (stall_cnt),
`endif
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Single-port memory model with one cycle of read latency
    always @(posedge ACLK) begin
        if (mem_en) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input logic l0,
                                 input logic [9:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic w1, input logic l1,
                                 input logic [9:0] a1, input logic [31:0] d1);
        @(negedge ACLK);
        m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
        #1;
    endtask

    task automatic doReset();
        @(negedge ACLK);
        ARESETn = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0;
        mem_rdata = 32'h0;
        ARESETn = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_lock = 1'b0; m0_addr = 10'd1; m0_wdata = 32'h1;
        m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b0; m1_addr = 10'd2; m1_wdata = 32'h2;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_m0_gnt", m0_gnt, 0);
        checkOutput("rst_m1_gnt", m1_gnt, 0);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_m0_rvalid", m0_rvalid, 0);
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0;

        $display("[TB] write then read-after-write on m0");
        applyStimulus(1, 1, 0, 10'd5, 32'hA5A5_0001, 0, 0, 0, 10'd0, 32'h0);
        checkOutput("wr_m0_gnt", m0_gnt, 1);
        checkOutput("wr_mem_en_before", mem_en, 0);
        applyStimulus(1, 0, 0, 10'd5, 32'h0, 0, 0, 0, 10'd0, 32'h0);
        checkOutput("rd_m0_gnt", m0_gnt, 1);
        checkOutput("wr_mem_en", mem_en, 1);
        checkOutput("wr_mem_we", mem_we, 1);
        checkOutput("wr_mem_addr", mem_addr, 5);
        checkOutput("wr_mem_wdata", mem_wdata, 32'hA5A5_0001);
        applyStimulus(0, 0, 0, 10'd0, 32'h0, 0, 0, 0, 10'd0, 32'h0);
        checkOutput("rd_mem_en", mem_en, 1);
        checkOutput("rd_mem_we", mem_we, 0);
        checkOutput("rd_m0_rvalid_early", m0_rvalid, 0);
        applyStimulus(0, 0, 0, 10'd0, 32'h0, 0, 0, 0, 10'd0, 32'h0);
        checkOutput("idle_mem_en", mem_en, 0);
        checkOutput("idle_mem_addr_hold", mem_addr, 5);
        checkOutput("rd_m0_rvalid", m0_rvalid, 1);
        checkOutput("rd_m0_rdata", m0_rdata, 32'hA5A5_0001);
        checkOutput("rd_m1_rvalid", m1_rvalid, 0);
        applyStimulus(0, 0, 0, 10'd0, 32'h0, 0, 0, 0, 10'd0, 32'h0);
        checkOutput("rd_m0_rvalid_after", m0_rvalid, 0);

        $display("[TB] round-robin contention after reset");
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, 0, 10'(16 + i), 32'(i), 1, 1, 0, 10'(32 + i), 32'(100 + i));
            checkOutput($sformatf("rr_m0_gnt_%0d", i), m0_gnt, (i % 2) == 0);
            checkOutput($sformatf("rr_m1_gnt_%0d", i), m1_gnt, (i % 2) == 1);
        end
        applyStimulus(0, 0, 0, 10'd0, 32'h0, 0, 0, 0, 10'd0, 32'h0);
`ifdef MEM_ARB_PERF_EN
        checkOutput("perf_m0_beats", m0_beats, 3);
        checkOutput("perf_m1_beats", m1_beats, 3);
        checkOutput("perf_stall_cnt", stall_cnt, 6);
`endif

        $display("[TB] burst lock on m0 with m1 waiting");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 1, 10'(64 + i), 32'(i), 1, 1, 0, 10'd80, 32'h80);
            checkOutput($sformatf("lock_m0_gnt_%0d", i), m0_gnt, i != 8);
            checkOutput($sformatf("lock_m1_gnt_%0d", i), m1_gnt, i == 8);
        end
        applyStimulus(0, 0, 0, 10'd0, 32'h0, 0, 0, 0, 10'd0, 32'h0);

        $display("[TB] interleaved reads");
        applyStimulus(1, 1, 0, 10'd3, 32'h3333_0003, 0, 0, 0, 10'd0, 32'h0);
        checkOutput("iw_m0_gnt", m0_gnt, 1);
        applyStimulus(0, 0, 0, 10'd0, 32'h0, 1, 1, 0, 10'd4, 32'h4444_0004);
        checkOutput("iw_m1_gnt", m1_gnt, 1);
        applyStimulus(1, 0, 0, 10'd3, 32'h0, 0, 0, 0, 10'd0, 32'h0);
        checkOutput("ir_m0_gnt", m0_gnt, 1);
        applyStimulus(0, 0, 0, 10'd0, 32'h0, 1, 0, 0, 10'd4, 32'h0);
        checkOutput("ir_m1_gnt", m1_gnt, 1);
        applyStimulus(0, 0, 0, 10'd0, 32'h0, 0, 0, 0, 10'd0, 32'h0);
        checkOutput("ir_m0_rvalid", m0_rvalid, 1);
        checkOutput("ir_m0_rdata", m0_rdata, 32'h3333_0003);
        checkOutput("ir_m1_rvalid_first", m1_rvalid, 0);
        applyStimulus(0, 0, 0, 10'd0, 32'h0, 0, 0, 0, 10'd0, 32'h0);
        checkOutput("ir_m1_rvalid", m1_rvalid, 1);
        checkOutput("ir_m1_rdata", m1_rdata, 32'h4444_0004);
        checkOutput("ir_m0_rvalid_second", m0_rvalid, 0);

        $display("[TB] reset during an in-flight read");
        applyStimulus(1, 0, 0, 10'd5, 32'h0, 0, 0, 0, 10'd0, 32'h0);
        checkOutput("rr_read_gnt", m0_gnt, 1);
        @(negedge ACLK);
        ARESETn = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        #1;
        checkOutput("mid_rst_mem_en", mem_en, 0);
        checkOutput("mid_rst_mem_we", mem_we, 0);
        checkOutput("mid_rst_mem_addr", mem_addr, 0);
        checkOutput("mid_rst_mem_wdata", mem_wdata, 0);
        checkOutput("mid_rst_m0_gnt", m0_gnt, 0);
        checkOutput("mid_rst_m1_gnt", m1_gnt, 0);
        checkOutput("mid_rst_m0_rvalid", m0_rvalid, 0);
        checkOutput("mid_rst_m0_rdata", m0_rdata, 0);
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 10'd0, 32'h0, 0, 0, 0, 10'd0, 32'h0);
            checkOutput($sformatf("post_rst_m0_rvalid_%0d", i), m0_rvalid, 0);
            checkOutput($sformatf("post_rst_m1_rvalid_%0d", i), m1_rvalid, 0);
        end
        applyStimulus(1, 1, 0, 10'd7, 32'h7, 1, 1, 0, 10'd8, 32'h8);
        checkOutput("post_rst_tie_m0", m0_gnt, 1);
        checkOutput("post_rst_tie_m1", m1_gnt, 0);
        applyStimulus(0, 0, 0, 10'd0, 32'h0, 0, 0, 0, 10'd0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
